// File: rtl/udalt_tick_ctrl_if.sv
// udalt_tick_ctrl_if: button inputs and pulse/status outputs of the tick controller
interface udalt_tick_ctrl_if;
  logic btn_run;
  logic btn_step;
  logic btn_clr;
  logic en;
  logic clr;
  logic running;
  modport master(output btn_run, btn_step, btn_clr, input en, clr, running);
  modport slave(input btn_run, btn_step, btn_clr, output en, clr, running);
endinterface

// File: rtl/udalt_tick_ctrl.sv
// udalt_tick_ctrl: debounced run/step/clear buttons driving count-enable and clear pulses
module udalt_tick_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DIV_W     = 26,
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input logic Clk,
  input logic reset,
  udalt_tick_ctrl_if.slave bus
);
  localparam logic [0:0] PAUSED  = 1'b0;
  localparam logic [0:0] RUNNING = 1'b1;
  logic [2:0] s1, s2, press;
  logic [0:0] state;
  logic [DIV_W-1:0] pre;
  logic tick;
  // two-flop synchronisers for {clr, step, run}
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {bus.btn_clr, bus.btn_step, bus.btn_run};
      s2 <= s1;
    end
  for (genvar b = 0; b < 3; b++) begin : g_db
    logic [DB_W-1:0] cnt;
    logic lvl, pr;
    // accept a new level after DB_CYCLES consecutive differing cycles; pulse on 0->1 only
    always_ff @(posedge Clk or negedge reset)
      if (!reset) begin
        cnt <= '0;
        lvl <= 1'b0;
        pr  <= 1'b0;
      end else if (s2[b] == lvl) begin
        cnt <= '0;
        pr  <= 1'b0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        cnt <= '0;
        lvl <= s2[b];
        pr  <= s2[b];
      end else begin
        cnt <= cnt + 1'b1;
        pr  <= 1'b0;
      end
    assign press[b] = pr;
  end
  assign tick = (state == RUNNING) && (pre == DIV_W'(TICK_DIV - 1));
  // run/pause FSM, prescaler and registered pulses; clr beats run beats step
  always_ff @(posedge Clk or negedge reset)
    if (!reset) begin
      state   <= PAUSED;
      pre     <= '0;
      bus.en  <= 1'b0;
      bus.clr <= 1'b0;
    end else begin
      bus.en  <= !press[2] && !press[0] && ((state == RUNNING) ? tick : press[1]);
      bus.clr <= press[2];
      state   <= press[2] ? PAUSED : press[0] ? ~state : state;
      pre     <= (press[2] || press[0] || state == PAUSED || tick) ? '0 : pre + 1'b1;
    end
  assign bus.running = (state == RUNNING);
endmodule
